piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in/serial-out shifter for the SPI
// datapath. A WIDTH-bit word is taken over a valid/ready handshake and moved
// out one bit per shift_en strobe, MSB or LSB first. A one-cycle done pulse
// follows the last bit of each word.
//
// Optional build macro PISO_PRELOAD_EN adds a one-word holding register so
// the next word can be queued during SHIFT and follow without a gap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word in flight; in_ready high, shift_en ignored, out_bit 0
// SHIFT | word in flight; out_bit valid, each shift_en consumes one bit
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_edge;

`ifdef PISO_PRELOAD_EN
    logic [WIDTH-1:0]   hold;
    logic               hold_valid;
`endif

    // Ready: a full holding register is the only back-pressure when preload
    // exists; otherwise the block takes a word only while idle.
`ifdef PISO_PRELOAD_EN
    assign in_ready = !hold_valid;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept    = in_valid & in_ready;
    assign last_edge = (state == SHIFT) & shift_en & (cnt == CNT_W'(1));

    // Output end is the top bit for MSB-first and bit 0 otherwise; the
    // zero-fill keeps out_bit low once a word has drained.
    assign out_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign out_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);

    // One-position shift toward the output end with zero fill.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST)
            shifted = {shreg[WIDTH-2:0], 1'b0};
        else
            shifted = {1'b0, shreg[WIDTH-1:1]};
    end

    // Sequencer: load on accept, shift per strobe, count down to the last bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef PISO_PRELOAD_EN
            hold       <= '0;
            hold_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shreg <= in_data;
                    cnt   <= CNT_W'(WIDTH);
                    state <= SHIFT;
                end
            end else begin
`ifdef PISO_PRELOAD_EN
                // A word arriving on the last-bit edge bypasses the hold
                // register and is loaded straight into the shifter below.
                if (accept && !last_edge) begin
                    hold       <= in_data;
                    hold_valid <= 1'b1;
                end
`endif
                if (shift_en) begin
                    shreg <= shifted;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        done <= 1'b1;
`ifdef PISO_PRELOAD_EN
                        if (hold_valid) begin
                            shreg      <= hold;
                            cnt        <= CNT_W'(WIDTH);
                            hold_valid <= 1'b0;
                        end else if (accept) begin
                            shreg <= in_data;
                            cnt   <= CNT_W'(WIDTH);
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first serializer with the
// same stimulus. A word-level reference model pushes each accepted word's bits
// onto per-instance stream queues; a negedge monitor pops one bit per consumed
// strobe and compares the serial outputs and handshake/status flags.
module tb_piso_serializer;

`ifdef PISO_PRELOAD_EN
    localparam int W   = 16;
    localparam bit PRE = 1'b1;
`else
    localparam int W   = 8;
    localparam bit PRE = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         shift_en = 1'b0;

    logic rdy_m, bit_m, ov_m, busy_m, done_m;
    logic rdy_l, bit_l, ov_l, busy_l, done_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .shift_en(shift_en), .out_bit(bit_m),
        .out_valid(ov_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .shift_en(shift_en), .out_bit(bit_l),
        .out_valid(ov_l), .busy(busy_l), .done(done_l)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-level view (busy, bits remaining, hold occupancy).
    bit m_busy = 1'b0;
    bit m_hold = 1'b0;
    bit m_done = 1'b0;
    int m_rem  = 0;
    bit q_m[$];
    bit q_l[$];
    int done_exp = 0;
    int done_seen_m = 0;
    int done_seen_l = 0;

    always @(posedge clock) begin
        bit acc, used, busy_pre;
        if (reset) begin
            m_busy = 1'b0;
            m_hold = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
            q_m.delete();
            q_l.delete();
        end else begin
            busy_pre = m_busy;
            used     = 1'b0;
            m_done   = 1'b0;
            acc      = in_valid && (PRE ? !m_hold : !m_busy);
            if (m_busy && shift_en) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    done_exp++;
                    if (m_hold) begin
                        m_hold = 1'b0;
                        m_rem  = W;
                    end else if (acc) begin
                        used  = 1'b1;
                        m_rem = W;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
            if (acc && !used) begin
                if (!busy_pre) begin
                    m_busy = 1'b1;
                    m_rem  = W;
                end else begin
                    m_hold = 1'b1;
                end
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(in_data[W-1-i]);
                    q_l.push_back(in_data[i]);
                end
            end
        end
    end

    // Monitor: compare every cycle, away from the active edge.
    always @(negedge clock) begin
        bit exp_m, exp_l;
        check("ready_m", rdy_m, PRE ? !m_hold : !m_busy);
        check("ready_l", rdy_l, PRE ? !m_hold : !m_busy);
        check("valid_m", ov_m, m_busy);
        check("valid_l", ov_l, m_busy);
        check("busy_m", busy_m, m_busy);
        check("busy_l", busy_l, m_busy);
        check("done_m", done_m, m_done);
        check("done_l", done_l, m_done);
        if (done_m) done_seen_m++;
        if (done_l) done_seen_l++;

        if (ov_m) begin
            if (q_m.size() == 0) begin
                check("stream_m_underflow", 1, 0);
            end else begin
                exp_m = q_m[0];
                check("bit_m", bit_m, exp_m);
                if (shift_en) void'(q_m.pop_front());
            end
        end else begin
            check("idle_bit_m", bit_m, 0);
        end

        if (ov_l) begin
            if (q_l.size() == 0) begin
                check("stream_l_underflow", 1, 0);
            end else begin
                exp_l = q_l[0];
                check("bit_l", bit_l, exp_l);
                if (shift_en) void'(q_l.pop_front());
            end
        end else begin
            check("idle_bit_l", bit_l, 0);
        end
    end

    // shift_en pattern generator: 0 = every cycle, 1 = every 4th, 2 = random.
    int se_mode = 0;
    initial begin
        int se_cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            case (se_mode)
                0: shift_en = 1'b1;
                1: begin
                    se_cnt++;
                    shift_en = ((se_cnt % 4) == 0);
                end
                default: shift_en = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a word and hold it until the accept edge has passed.
    task automatic send(input logic [31:0] d, input bit drop_after);
        bit rdy, ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d[W-1:0];
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            rdy = rdy_m;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 1, 0);
        if (drop_after) begin
            in_valid = 1'b0;
            in_data  = W'($urandom());
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!busy_m && !busy_l) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 1, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", rdy_m, 1);
        check("rst_valid", ov_m, 0);
        check("rst_bit", bit_m, 0);
        check("rst_done", done_m, 0);
        tick();

        // Continuous strobes
        se_mode = 0;
        send(32'hA5, 1'b1);
        wait_idle();
        send(32'h01, 1'b1);
        wait_idle();

        // Sparse strobes
        se_mode = 1;
        send(32'hF0, 1'b1);
        wait_idle();

        // Reset after three bits of a word, then a clean word
        se_mode = 0;
        send(32'hC3, 1'b1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("midrst_valid", ov_m, 0);
        check("midrst_bit_m", bit_m, 0);
        check("midrst_bit_l", bit_l, 0);
        check("midrst_ready", rdy_m, 1);
        check("midrst_done", done_m, 0);
        tick();
        send(32'h3C, 1'b1);
        wait_idle();

        // in_valid held high across consecutive words
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        wait_idle();
        send(32'hBEEF, 1'b0);
        send(32'h1234, 1'b1);
        wait_idle();

        // Randomised words, strobe patterns and inter-word gaps
        for (int k = 0; k < 40; k++) begin
            se_mode = (k < 20) ? 2 : 0;
            send($urandom(), ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 3)) tick();
            if ((k % 10) == 9) begin
                in_valid = 1'b0;
                wait_idle();
            end
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (4) tick();

        check("done_count_m", done_seen_m, done_exp);
        check("done_count_l", done_seen_l, done_exp);
        check("stream_m_drained", q_m.size(), 0);
        check("stream_l_drained", q_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
